// File: rtl/hc_stream_copy_if.sv
// hc_stream_copy_if: control, read-stream and write-stream signals
// for the buffer-to-buffer line copy engine.
interface hc_stream_copy_if #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 8,
  parameter int CNT_W  = 32
);
  logic              start;
  logic [ID_W-1:0]   src_id;
  logic [ID_W-1:0]   dst_id;
  logic [CNT_W-1:0]  num_lines;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_req_valid;
  logic [ID_W-1:0]   rd_req_id;
  logic [CNT_W-1:0]  rd_req_offset;
  logic              rd_full;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              wr_req_valid;
  logic [ID_W-1:0]   wr_req_id;
  logic [DATA_W-1:0] wr_data;
  logic              wr_full;

  modport master (
    input  start, src_id, dst_id, num_lines,
    input  rd_full, rx_valid, rx_data, wr_full,
    output busy, done, err,
    output rd_req_valid, rd_req_id, rd_req_offset,
    output wr_req_valid, wr_req_id, wr_data
  );

  modport slave (
    output start, src_id, dst_id, num_lines,
    output rd_full, rx_valid, rx_data, wr_full,
    input  busy, done, err,
    input  rd_req_valid, rd_req_id, rd_req_offset,
    input  wr_req_valid, wr_req_id, wr_data
  );
endinterface

// File: rtl/hc_stream_copy.sv
// hc_stream_copy: streams num_lines cache lines from a source buffer
// to a destination buffer through a credit-limited data FIFO.
module hc_stream_copy #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 8,
  parameter int CNT_W  = 32,
  parameter int DEPTH  = 8
) (
  input logic clk,
  input logic reset,
  hc_stream_copy_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ID_W-1:0]   src_q, dst_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  rd_cnt_q, rx_cnt_q, wr_cnt_q;
  logic [AW-1:0]     wptr_q, rptr_q;
  logic [AW:0]       fcnt_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy_q, done_q, err_q;
  logic              rdv_q, wrv_q;
  logic [ID_W-1:0]   rdid_q, wrid_q;
  logic [CNT_W-1:0]  rdoff_q;
  logic [DATA_W-1:0] wrdata_q;

  logic             in_run, accept;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] credit;
  logic             rd_go, push, pop, rx_bad, wr_last;

  assign in_run     = (state_q == S_RUN);
  assign accept     = (state_q == S_IDLE) && bus.start;
  assign fifo_full  = (fcnt_q == (AW+1)'(DEPTH));
  assign fifo_empty = (fcnt_q == '0);

  // Lines in flight plus lines buffered must fit the FIFO.
  assign credit = (rd_cnt_q - rx_cnt_q) + CNT_W'(fcnt_q);

  assign rd_go = in_run && (rd_cnt_q < num_q) &&
                 !bus.rd_full && (credit < CNT_W'(DEPTH));
  assign push    = in_run && bus.rx_valid && !fifo_full;
  assign rx_bad  = bus.rx_valid && !push;
  assign pop     = in_run && !fifo_empty && !bus.wr_full;
  assign wr_last = pop && ((wr_cnt_q + CNT_W'(1)) == num_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start)
          state_d = (bus.num_lines == '0) ? S_DONE : S_RUN;
      end
      S_RUN:   if (wr_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      num_q    <= '0;
      rd_cnt_q <= '0;
      rx_cnt_q <= '0;
      wr_cnt_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q    <= bus.src_id;
        dst_q    <= bus.dst_id;
        num_q    <= bus.num_lines;
        rd_cnt_q <= '0;
        rx_cnt_q <= '0;
        wr_cnt_q <= '0;
        wptr_q   <= '0;
        rptr_q   <= '0;
        fcnt_q   <= '0;
      end else begin
        if (rd_go) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
        if (push) begin
          rx_cnt_q <= rx_cnt_q + CNT_W'(1);
          wptr_q   <= wptr_q + AW'(1);
        end
        if (pop) begin
          wr_cnt_q <= wr_cnt_q + CNT_W'(1);
          rptr_q   <= rptr_q + AW'(1);
        end
        fcnt_q <= fcnt_q + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= bus.rx_data;
  end

  // done trails the DONE state by one cycle so it is purely registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdv_q    <= 1'b0;
      rdid_q   <= '0;
      rdoff_q  <= '0;
      wrv_q    <= 1'b0;
      wrid_q   <= '0;
      wrdata_q <= '0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_q == S_DONE);
      err_q  <= err_q | rx_bad;
      rdv_q  <= rd_go;
      if (rd_go) begin
        rdid_q  <= src_q;
        rdoff_q <= rd_cnt_q;
      end
      wrv_q <= pop;
      if (pop) begin
        wrid_q   <= dst_q;
        wrdata_q <= mem[rptr_q];
      end
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.rd_req_valid  = rdv_q;
  assign bus.rd_req_id     = rdid_q;
  assign bus.rd_req_offset = rdoff_q;
  assign bus.wr_req_valid  = wrv_q;
  assign bus.wr_req_id     = wrid_q;
  assign bus.wr_data       = wrdata_q;
endmodule

// File: tb/tb_hc_stream_copy.sv
// tb_hc_stream_copy: randomized copies checked against a queue-based
// model of the read/return/write line stream.
module tb_hc_stream_copy;
  localparam int DW = 512;
  localparam int IW = 8;
  localparam int CW = 32;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hc_stream_copy_if #(.DATA_W(DW), .ID_W(IW), .CNT_W(CW)) bus ();

  hc_stream_copy #(
    .DATA_W(DW), .ID_W(IW), .CNT_W(CW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int pass_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int rd_seen, wr_seen, done_seen;
  int first_rd_cyc, first_wr_cyc, done_cyc;
  int max_credit, start_cyc;
  logic [IW-1:0] exp_src, exp_dst;
  logic [DW-1:0] expq[$];
  int dueq[$];
  int last_due;
  int lat_min = 3, lat_max = 3;
  int rdf_mode = 0;
  int wr_hold_until = 0;
  bit wr_rand = 0;
  bit prev_rdf = 0, prev_wrf = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    int d;
    logic [DW-1:0] line;
    @(negedge clk);
    cyc++;
    if (bus.rd_req_valid) begin
      chk("rd_after_full", !prev_rdf, 1);
      chk("rd_id", bus.rd_req_id, exp_src);
      chk("rd_off", bus.rd_req_offset, rd_seen);
      if (rd_seen == 0) first_rd_cyc = cyc;
      rd_seen++;
      d = cyc + $urandom_range(lat_max, lat_min);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      dueq.push_back(d);
    end
    if (bus.wr_req_valid) begin
      chk("wr_after_full", !prev_wrf, 1);
      chk("wr_id", bus.wr_req_id, exp_dst);
      if (expq.size() == 0) chk("wr_unexpected", 1, 0);
      else chk("wr_data", bus.wr_data, expq.pop_front());
      if (wr_seen == 0) first_wr_cyc = cyc;
      wr_seen++;
    end
    if (rd_seen - wr_seen > max_credit) max_credit = rd_seen - wr_seen;
    if (bus.done) begin
      done_seen++;
      done_cyc = cyc;
    end
    bus.rx_valid = 1'b0;
    if (dueq.size() > 0 && dueq[0] == cyc) begin
      void'(dueq.pop_front());
      line = rand_line();
      bus.rx_data = line;
      bus.rx_valid = 1'b1;
      expq.push_back(line);
    end
    case (rdf_mode)
      1: bus.rd_full = (cyc % 2) == 1;
      2: bus.rd_full = ($urandom_range(3, 0) == 0);
      default: bus.rd_full = 1'b0;
    endcase
    bus.wr_full = (cyc < wr_hold_until) ||
                  (wr_rand && $urandom_range(2, 0) == 0);
    prev_rdf = bus.rd_full;
    prev_wrf = bus.wr_full;
  endtask

  task automatic start_copy(input int s, input int dd, input int n);
    exp_src = IW'(s);
    exp_dst = IW'(dd);
    rd_seen = 0;
    wr_seen = 0;
    max_credit = 0;
    expq.delete();
    dueq.delete();
    last_due = 0;
    first_rd_cyc = -1;
    first_wr_cyc = -1;
    done_cyc = -1;
    bus.src_id = IW'(s);
    bus.dst_id = IW'(dd);
    bus.num_lines = CW'(n);
    bus.start = 1'b1;
    start_cyc = cyc;
    step();
    bus.start = 1'b0;
    bus.src_id = '1;
    bus.dst_id = '1;
    bus.num_lines = 5;
  endtask

  task automatic wait_done(input int budget);
    int b;
    b = done_seen;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_seen != b) break;
    end
    chk("done_timeout", done_seen != b, 1);
    for (int i = 0; i < 3; i++) step();
    chk("done_once", done_seen - b, 1);
  endtask

  task automatic finish_copy(input int n);
    chk("rd_count", rd_seen, n);
    chk("wr_count", wr_seen, n);
    chk("model_empty", expq.size(), 0);
    chk("credit_max", max_credit <= DEPTH, 1);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, bus.busy, 0);
    chk({nm, "_done"}, bus.done, 0);
    chk({nm, "_err"}, bus.err, 0);
    chk({nm, "_rdv"}, bus.rd_req_valid, 0);
    chk({nm, "_wrv"}, bus.wr_req_valid, 0);
    chk({nm, "_rdid"}, bus.rd_req_id, 0);
    chk({nm, "_rdoff"}, bus.rd_req_offset, 0);
    chk({nm, "_wrid"}, bus.wr_req_id, 0);
    chk({nm, "_wrdata"}, bus.wr_data, 0);
  endtask

  initial begin
    int n, w0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.src_id = '0;
    bus.dst_id = '0;
    bus.num_lines = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data = '0;
    bus.rd_full = 1'b0;
    bus.wr_full = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 3; i++) step();
    chk_idle("reset");
    reset = 1'b0;
    step();

    start_copy(1, 2, 4);
    chk("busy_run", bus.busy, 1);
    wait_done(80);
    finish_copy(4);
    chk("t041_first_rd", first_rd_cyc, start_cyc + 2);
    chk("t041_first_wr", first_wr_cyc, start_cyc + 7);
    chk("t041_done", done_cyc, start_cyc + 11);

    start_copy(3, 4, 0);
    wait_done(20);
    chk("t043_done", done_cyc, start_cyc + 2);
    chk("t043_rd", rd_seen, 0);
    chk("t043_wr", wr_seen, 0);

    rdf_mode = 1;
    start_copy(9, 10, 6);
    wait_done(120);
    finish_copy(6);
    rdf_mode = 0;

    lat_min = 2;
    lat_max = 5;
    wr_hold_until = cyc + 31;
    start_copy(11, 12, 20);
    wait_done(300);
    finish_copy(20);
    chk("t042_credit_full", max_credit, DEPTH);
    chk("t042_err", bus.err, 0);

    rdf_mode = 2;
    wr_rand = 1;
    lat_min = 1;
    lat_max = 6;
    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(25, 1);
      start_copy($urandom_range(255, 0), $urandom_range(255, 0), n);
      wait_done(600);
      finish_copy(n);
    end
    chk("rand_err", bus.err, 0);
    rdf_mode = 0;
    wr_rand = 0;
    lat_min = 3;
    lat_max = 3;

    step();
    w0 = wr_seen;
    bus.rx_data = rand_line();
    bus.rx_valid = 1'b1;
    step();
    for (int i = 0; i < 3; i++) step();
    chk("t045_err", bus.err, 1);
    for (int i = 0; i < 5; i++) step();
    chk("t045_err_sticky", bus.err, 1);
    chk("t045_no_wr", wr_seen, w0);

    start_copy(5, 6, 10);
    for (int i = 0; i < 100; i++) begin
      if (wr_seen >= 3) break;
      step();
    end
    chk("t046_three_written", wr_seen, 3);
    reset = 1'b1;
    dueq.delete();
    expq.delete();
    #1;
    chk_idle("t046_reset");
    step();
    step();
    reset = 1'b0;
    step();
    start_copy(7, 8, 2);
    wait_done(60);
    finish_copy(2);
    chk("t046_err", bus.err, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/hc_stream_copy.md
HC_STREAM_COPY -- requirements
Module: hc_stream_copy

Interface
REQ-001 Parameter DATA_W, default 512, cache-line data width.
REQ-002 Parameter ID_W, default 8, buffer id width.
REQ-003 Parameter CNT_W, default 32, line count and offset width.
REQ-004 Parameter DEPTH, default 8 (power of 2, >=2), data FIFO depth in lines.
REQ-005 clk  in  1  Single clock; all logic on the rising edge.
REQ-006 reset  in  1  Asynchronous, active-high reset.
REQ-007 start  in  1  One-cycle copy request pulse; sampled only in IDLE.
REQ-008 src_id  in  ID_W  Source buffer id, captured on an accepted start.
REQ-009 dst_id  in  ID_W  Destination buffer id, captured on an accepted start.
REQ-010 num_lines  in  CNT_W  Lines to copy, captured on an accepted start.
REQ-011 busy  out  1  High in RUN and DONE.
REQ-012 done  out  1  One-cycle completion pulse.
REQ-013 err  out  1  Sticky protocol-error flag; cleared only by reset.
REQ-014 rd_req_valid  out  1  Read-stream request to the buffer stage this cycle.
REQ-015 rd_req_id  out  ID_W  Read request buffer id.
REQ-016 rd_req_offset  out  CNT_W  Read request line offset.
REQ-017 rd_full  in  1  Read request queue full.
REQ-018 rx_valid  in  1  Returned read line valid.
REQ-019 rx_data  in  DATA_W  Returned read line data.
REQ-020 wr_req_valid  out  1  Write-stream request with data this cycle.
REQ-021 wr_req_id  out  ID_W  Write request buffer id.
REQ-022 wr_data  out  DATA_W  Write request line data.
REQ-023 wr_full  in  1  Write request queue full.

Function
REQ-024 FSM states: IDLE, RUN, DONE; every output is registered.
REQ-025 IDLE: start=1 with num_lines>0 -> RUN; start=1 with num_lines=0 -> DONE; capture src_id, dst_id, num_lines; clear rd_cnt, rx_cnt, wr_cnt.
REQ-026 start is ignored outside IDLE; captured values stay unchanged.
REQ-027 Read issue condition: state RUN, rd_cnt<num_lines, rd_full=0, and (rd_cnt-rx_cnt)+fifo_count < DEPTH.
REQ-028 On the cycle after the issue condition holds, rd_req_valid=1, rd_req_id=src_id, rd_req_offset=rd_cnt (pre-increment); rd_cnt increments by 1.
REQ-029 rd_req_valid is low whenever the issue condition is false; at most one read request per cycle.
REQ-030 Accepted rx_valid in RUN writes rx_data into the FIFO and increments rx_cnt; data order is preserved.
REQ-031 rx_valid in IDLE or DONE, or with the FIFO full: drop the data and set err=1.
REQ-032 Write issue: FIFO non-empty and wr_full=0 -> next cycle wr_req_valid=1, wr_req_id=dst_id, wr_data=FIFO head; pop the FIFO; wr_cnt increments by 1.
REQ-033 Minimum latency from rx_valid to the matching wr_req_valid is 2 cycles.
REQ-034 Simultaneous FIFO push and pop in one cycle is legal; fifo_count is unchanged.
REQ-035 RUN -> DONE in the cycle wr_cnt reaches num_lines; DONE lasts exactly 1 cycle with done=1, then -> IDLE.
REQ-036 Counters are CNT_W wide; the credit sum never exceeds DEPTH, so no wrap-around occurs within a copy.

Reset
REQ-037 reset=1 at any time, including mid-copy, forces IDLE immediately.
REQ-038 reset clears all counters, the FIFO, and captured registers.
REQ-039 During reset, busy, done, err, rd_req_valid and wr_req_valid are 0; ids, offset and wr_data are 0.
REQ-040 After reset deasserts, the first start is accepted normally.

Verification
REQ-041 num_lines=4, src=1, dst=2, no backpressure, rx returns 3 cycles after each request -> rd_req offsets 0,1,2,3 on id 1; four writes on id 2 with data in order; one done pulse.
REQ-042 num_lines=20, wr_full held high for 30 cycles -> outstanding reads plus FIFO count never exceed 8; all 20 lines written in order after release; err=0.
REQ-043 num_lines=0 -> done pulses 2 cycles after start; no rd_req_valid or wr_req_valid ever asserted.
REQ-044 rd_full toggled every other cycle, num_lines=6 -> no rd_req_valid in any cycle following rd_full=1; 6 writes completed.
REQ-045 Spurious rx_valid in IDLE -> err=1 and stays 1; no write issued.
REQ-046 reset asserted after 3 of 10 lines written, then a new start with num_lines=2 -> immediate idle outputs; the new copy uses offsets 0,1 and completes with one done pulse.
